trace_lockstep_checker: RTL and testbench

- Consumes the two retired-instruction trace streams (valid + 36-bit word) and the two trap flags from the reference core wrapper and the mixed-language core wrapper, which run side by side under one clock.
- Buffers each stream in a small FIFO so the cores may drift by up to DEPTH words, then compares the words in order.
- Reports the first divergence with its index and both words, reports FIFO overflow and unequal stream lengths, and signals completion once both cores have trapped and every word has matched.
- Synthesisable, so it can run in the simulation bench or on an FPGA build.

---
 rtl/trace_chk_pkg.sv | 14 +
 rtl/trace_fifo.sv | 47 ++++
 rtl/trace_lockstep_checker.sv | 132 +++++++++++++
 tb/tb_trace_lockstep_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/trace_chk_pkg.sv
// Shared definitions for the lockstep trace checker.
package trace_chk_pkg;

  localparam int TRACE_W_DEF = 36;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAIL  = 2'b11
  } chk_state_e;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO; the caller guarantees push is never issued
// into a full FIFO without a simultaneous pop.
module trace_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the low bits match.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage carries no reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update with synchronous clear taking priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trace_lockstep_checker.sv
// Compares two retired-instruction trace streams word by word, tolerating
// up to DEPTH words of drift, and records the first divergence.
module trace_lockstep_checker
  import trace_chk_pkg::*;
#(
  parameter int TRACE_W = TRACE_W_DEF,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               a_valid,
  input  logic [TRACE_W-1:0] a_data,
  input  logic               a_trap,
  input  logic               b_valid,
  input  logic [TRACE_W-1:0] b_data,
  input  logic               b_trap,
  output logic [1:0]         state,
  output logic               done,
  output logic               mismatch,
  output logic               overflow,
  output logic               length_err,
  output logic [CNT_W-1:0]   match_count,
  output logic [CNT_W-1:0]   mis_index,
  output logic [TRACE_W-1:0] mis_a_data,
  output logic [TRACE_W-1:0] mis_b_data
);

  // Lane 0 is the reference stream, lane 1 the mixed-language stream.
  logic [1:0]              vld, push, pop, empty, full, ovf, trap_q, trap_any;
  logic [1:0][TRACE_W-1:0] din, dout;
  logic                    active, cmp, mis, len_err, both_trap;
  chk_state_e              state_q, state_d;

  assign vld = {b_valid, a_valid};
  assign din = {b_data, a_data};

  for (genvar i = 0; i < 2; i++) begin : g_lane
    trace_fifo #(.W(TRACE_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .clear  (clear),
      .push   (push[i]),
      .pop    (pop[i]),
      .din    (din[i]),
      .dout   (dout[i]),
      .empty  (empty[i]),
      .full   (full[i])
    );
  end

  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign cmp       = active && !empty[0] && !empty[1];
  assign mis       = cmp && (dout[0] != dout[1]);
  assign pop       = {2{cmp}};
  assign trap_any  = trap_q | {b_trap, a_trap};
  assign both_trap = &trap_any;

  // A push into a full FIFO is only accepted when the same edge frees a slot.
  always_comb begin
    push = '0;
    ovf  = '0;
    for (int i = 0; i < 2; i++) begin
      push[i] = active && vld[i] && (!full[i] || pop[i]);
      ovf[i]  = active && vld[i] && full[i] && !pop[i];
    end
  end

  // Once both cores have stopped, a lone leftover word can never be matched.
  assign len_err = (state_q == ST_DRAIN) &&
                   ((empty[0] && !empty[1] && !push[0]) ||
                    (empty[1] && !empty[0] && !push[1]));

  // Next-state: errors dominate, then trap/drain progression.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mis || |ovf)    state_d = ST_FAIL;
        else if (both_trap) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mis || |ovf || len_err) state_d = ST_FAIL;
        else if (&empty)            state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // State, trap latches, sticky flags, counter and first-mismatch capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      trap_q      <= '0;
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
      length_err  <= 1'b0;
      match_count <= '0;
      mis_index   <= '0;
      mis_a_data  <= '0;
      mis_b_data  <= '0;
    end else if (clear) begin
      state_q     <= ST_RUN;
      trap_q      <= '0;
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
      length_err  <= 1'b0;
      match_count <= '0;
      mis_index   <= '0;
      mis_a_data  <= '0;
      mis_b_data  <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_any;
      if (|ovf)    overflow   <= 1'b1;
      if (len_err) length_err <= 1'b1;
      if (mis) begin
        mismatch   <= 1'b1;
        mis_index  <= match_count;
        mis_a_data <= dout[0];
        mis_b_data <= dout[1];
      end else if (cmp && match_count != '1) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  assign state = state_q;
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Directed bench for the lockstep trace checker.
module tb_trace_lockstep_checker;

  localparam int TW = 36;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          resetn, clear;
  logic          a_valid, a_trap, b_valid, b_trap;
  logic [TW-1:0] a_data, b_data;
  logic [1:0]    state;
  logic          done, mismatch, overflow, length_err;
  logic [CW-1:0] match_count, mis_index;
  logic [TW-1:0] mis_a_data, mis_b_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trace_lockstep_checker #(.TRACE_W(TW), .DEPTH(16), .CNT_W(CW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (clear),
    .a_valid     (a_valid),
    .a_data      (a_data),
    .a_trap      (a_trap),
    .b_valid     (b_valid),
    .b_data      (b_data),
    .b_trap      (b_trap),
    .state       (state),
    .done        (done),
    .mismatch    (mismatch),
    .overflow    (overflow),
    .length_err  (length_err),
    .match_count (match_count),
    .mis_index   (mis_index),
    .mis_a_data  (mis_a_data),
    .mis_b_data  (mis_b_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data  = '0;   b_data  = '0;
  endtask

  task automatic do_reset;
    resetn = 1'b0; clear = 1'b0;
    a_trap = 1'b0; b_trap = 1'b0;
    idle();
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic push2(input logic av, input logic [TW-1:0] ad,
                       input logic bv, input logic [TW-1:0] bd);
    a_valid = av; a_data = ad;
    b_valid = bv; b_data = bd;
    tick();
    idle();
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    for (int i = 0; i < 40 && state !== s; i++) tick();
    chk(tag, 64'(state), 64'(s));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"},    64'(state),       64'd0);
    chk({tag, ".done"},     64'(done),        64'd0);
    chk({tag, ".mismatch"}, 64'(mismatch),    64'd0);
    chk({tag, ".overflow"}, 64'(overflow),    64'd0);
    chk({tag, ".len_err"},  64'(length_err),  64'd0);
    chk({tag, ".count"},    64'(match_count), 64'd0);
    chk({tag, ".mis_idx"},  64'(mis_index),   64'd0);
    chk({tag, ".mis_a"},    64'(mis_a_data),  64'd0);
    chk({tag, ".mis_b"},    64'(mis_b_data),  64'd0);
  endtask

  initial begin
    do_reset();
    chk_zero("reset");

    // Lockstep equal streams, 100 words.
    for (int i = 1; i <= 100; i++) push2(1'b1, TW'(i), 1'b1, TW'(i));
    repeat (5) tick();
    a_trap = 1'b1; b_trap = 1'b1;
    wait_state(2'b10, "lock.state");
    chk("lock.done",  64'(done),        64'd1);
    chk("lock.count", 64'(match_count), 64'd100);
    chk("lock.flags", 64'({mismatch, overflow, length_err}), 64'd0);

    // B delayed 10 cycles behind A, 50 words.
    do_reset();
    for (int c = 0; c < 60; c++)
      push2(c < 50, TW'(c + 1), c >= 10, TW'(c - 9));
    a_trap = 1'b1; b_trap = 1'b1;
    wait_state(2'b10, "skew.state");
    chk("skew.count", 64'(match_count), 64'd50);
    chk("skew.ovf",   64'(overflow),    64'd0);

    // Word 7 differs.
    do_reset();
    for (int i = 0; i < 10; i++)
      push2(1'b1, TW'(i + 1), 1'b1, (i == 7) ? 36'h0_DEAD_BEEF : TW'(i + 1));
    tick();
    chk("mis.flag",  64'(mismatch),    64'd1);
    chk("mis.index", 64'(mis_index),   64'd7);
    chk("mis.a",     64'(mis_a_data),  64'h0_0000_0008);
    chk("mis.b",     64'(mis_b_data),  64'h0_DEAD_BEEF);
    chk("mis.state", 64'(state),       64'd3);
    chk("mis.count", 64'(match_count), 64'd7);
    chk("mis.done",  64'(done),        64'd0);

    // A fills its FIFO while B idles; the 17th push overflows.
    do_reset();
    for (int i = 1; i <= 16; i++) push2(1'b1, TW'(i), 1'b0, '0);
    chk("ovf.pre_flag",  64'(overflow), 64'd0);
    chk("ovf.pre_state", 64'(state),    64'd0);
    push2(1'b1, TW'(17), 1'b0, '0);
    chk("ovf.flag",  64'(overflow), 64'd1);
    chk("ovf.state", 64'(state),    64'd3);

    // Push into a full FIFO on an edge that also pops is accepted.
    do_reset();
    for (int i = 1; i <= 16; i++) push2(1'b1, TW'(i), 1'b0, '0);
    push2(1'b0, '0, 1'b1, TW'(1));
    push2(1'b1, TW'(17), 1'b1, TW'(2));
    chk("fullpop.ovf", 64'(overflow), 64'd0);
    for (int i = 3; i <= 17; i++) push2(1'b0, '0, 1'b1, TW'(i));
    tick();
    a_trap = 1'b1; b_trap = 1'b1;
    wait_state(2'b10, "fullpop.state");
    chk("fullpop.count", 64'(match_count), 64'd17);

    // A sends 20 words, B sends 19.
    do_reset();
    for (int i = 1; i <= 20; i++) push2(1'b1, TW'(i), i <= 19, TW'(i));
    repeat (3) tick();
    chk("len.run_state", 64'(state), 64'd0);
    a_trap = 1'b1; b_trap = 1'b1;
    wait_state(2'b11, "len.state");
    chk("len.flag",  64'(length_err),  64'd1);
    chk("len.count", 64'(match_count), 64'd19);
    chk("len.mis",   64'(mismatch),    64'd0);

    // Asynchronous reset between edges after 5 matches.
    do_reset();
    for (int i = 1; i <= 5; i++) push2(1'b1, TW'(i), 1'b1, TW'(i));
    tick();
    chk("arst.pre_count", 64'(match_count), 64'd5);
    #2 resetn = 1'b0;
    #1 chk_zero("arst");
    #1 resetn = 1'b1;
    tick();

    // Synchronous clear after 5 matches.
    for (int i = 1; i <= 5; i++) push2(1'b1, TW'(i), 1'b1, TW'(i));
    tick();
    chk("clr.pre_count", 64'(match_count), 64'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_zero("clr");

    // Fresh stream after clear; a single trap must not leave RUN.
    for (int i = 1; i <= 8; i++) push2(1'b1, TW'(i + 40), 1'b1, TW'(i + 40));
    a_trap = 1'b1;
    tick();
    a_trap = 1'b0;
    repeat (3) tick();
    chk("fresh.one_trap", 64'(state), 64'd0);
    b_trap = 1'b1;
    tick();
    b_trap = 1'b0;
    wait_state(2'b10, "fresh.state");
    chk("fresh.count", 64'(match_count), 64'd8);
    chk("fresh.done",  64'(done),        64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
